// File: rtl/hazard_control_unit_types_pkg.sv
// Types shared by the hazard control unit and the branch predictor:
// next-PC mux select, BTB entry layout and 2-bit counter helpers.
package hazard_control_unit_types_pkg;

  typedef enum logic [2:0] {
    PCNPC    = 3'd0,
    PCBPC    = 3'd1,
    PCJPC    = 3'd2,
    PCPTA    = 3'd3,
    PRBPC    = 3'd4,
    PCERROR5 = 3'd5,
    PCERROR6 = 3'd6,
    PCERROR7 = 3'd7
  } pcselect_t;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // tag is pc[31:2] shifted right by the index width, zero-extended to 30 bits
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [31:0] target;
    logic [1:0]  cnt;
  } btb_entry_t;

  function automatic logic [1:0] cnt_step(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == ST)  ? ST  : cnt + 2'd1;
    else       return (cnt == SNT) ? SNT : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit saturating counters: combinational lookup port
// and a clocked update port driven by resolved EX branches.
module branch_target_buffer
  import hazard_control_unit_types_pkg::*;
#(
  parameter int ENTRIES = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] lk_pc,
  output logic        lk_hit,
  output logic [1:0]  lk_cnt,
  output logic [31:0] lk_target,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target
);
  localparam int IDXW = $clog2(ENTRIES);

  btb_entry_t tbl [ENTRIES];

  logic [IDXW-1:0] lk_idx, up_idx;
  logic [29:0]     lk_tag, up_tag;
  btb_entry_t      lk_e, up_e;
  logic            up_hit;

  assign lk_idx = lk_pc[IDXW+1:2];
  assign up_idx = upd_pc[IDXW+1:2];
  assign lk_tag = lk_pc[31:2] >> IDXW;
  assign up_tag = upd_pc[31:2] >> IDXW;
  assign lk_e   = tbl[lk_idx];
  assign up_e   = tbl[up_idx];

  assign lk_hit    = lk_e.valid && (lk_e.tag == lk_tag);
  assign lk_cnt    = lk_e.cnt;
  assign lk_target = lk_e.target;
  assign up_hit    = up_e.valid && (up_e.tag == up_tag);

  // lookup reads the pre-update entry; no bypass from the update port
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: WNT};
      end
    end else if (upd_en) begin
      if (up_hit) begin
        tbl[up_idx].cnt <= cnt_step(up_e.cnt, upd_taken);
      end else if (upd_taken) begin
        tbl[up_idx] <= '{valid: 1'b1, tag: up_tag, target: upd_target, cnt: WT};
      end
    end
  end

endmodule

// File: rtl/branch_predict_control.sv
// Next-PC sequencing for the 5-stage pipeline: IF prediction from the BTB,
// EX mispredict recovery, jump redirect, flushes and branch statistics.
module branch_predict_control
  import hazard_control_unit_types_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int CNTW    = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [31:0]     if_pc,
  input  logic            if_valid,
  input  logic            id_jump,
  input  logic            ex_branch,
  input  logic [31:0]     ex_pc,
  input  logic            ex_taken,
  input  logic [31:0]     ex_target,
  input  logic            ex_predtaken,
  input  logic            pipe_stall,
  output pcselect_t       pcselect,
  output logic            pred_taken,
  output logic [31:0]     pred_target,
  output logic            flush_ifid,
  output logic            flush_idex,
  output logic [CNTW-1:0] branch_count,
  output logic [CNTW-1:0] mispredict_count
);
  logic        lk_hit;
  logic [1:0]  lk_cnt;
  logic [31:0] lk_target;
  logic        mis_t, mis_n, upd_en;

  branch_target_buffer #(.ENTRIES(ENTRIES)) u_btb (
    .CLK        (CLK),
    .RST        (RST),
    .lk_pc      (if_pc),
    .lk_hit     (lk_hit),
    .lk_cnt     (lk_cnt),
    .lk_target  (lk_target),
    .upd_en     (upd_en),
    .upd_pc     (ex_pc),
    .upd_taken  (ex_taken),
    .upd_target (ex_target)
  );

  assign pred_taken  = if_valid & lk_hit & lk_cnt[1];
  assign pred_target = lk_hit ? lk_target : 32'h0;

  assign mis_t  = ex_branch & ex_taken & ~ex_predtaken;
  assign mis_n  = ex_branch & ~ex_taken & ex_predtaken;
  assign upd_en = ex_branch & ~pipe_stall;

  // EX recovery outranks an ID jump, which outranks an IF prediction
  always_comb begin
    pcselect   = PCNPC;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    if (mis_t) begin
      pcselect   = PCBPC;
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end else if (mis_n) begin
      pcselect   = PRBPC;
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end else if (id_jump) begin
      pcselect   = PCJPC;
      flush_ifid = 1'b1;
    end else if (pred_taken) begin
      pcselect   = PCPTA;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (upd_en) begin
      branch_count <= branch_count + 1'b1;
      if (mis_t | mis_n) mispredict_count <= mispredict_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_predict_control.sv
// Directed bench for branch_predict_control with ENTRIES=4, hand-computed
// expectations for prediction, recovery priority, saturation, aliasing and stall.
module tb_branch_predict_control;
  import hazard_control_unit_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] if_pc = '0;
  logic        if_valid = 1'b0;
  logic        id_jump = 1'b0;
  logic        ex_branch = 1'b0;
  logic [31:0] ex_pc = '0;
  logic        ex_taken = 1'b0;
  logic [31:0] ex_target = '0;
  logic        ex_predtaken = 1'b0;
  logic        pipe_stall = 1'b0;
  pcselect_t   pcselect;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        flush_ifid, flush_idex;
  logic [31:0] branch_count, mispredict_count;

  int n_cmp = 0;
  int n_bad = 0;

  branch_predict_control #(.ENTRIES(4), .CNTW(32)) dut (
    .CLK              (CLK),
    .RST              (RST),
    .if_pc            (if_pc),
    .if_valid         (if_valid),
    .id_jump          (id_jump),
    .ex_branch        (ex_branch),
    .ex_pc            (ex_pc),
    .ex_taken         (ex_taken),
    .ex_target        (ex_target),
    .ex_predtaken     (ex_predtaken),
    .pipe_stall       (pipe_stall),
    .pcselect         (pcselect),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .flush_ifid       (flush_ifid),
    .flush_idex       (flush_idex),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic look(input logic [31:0] pc);
    if_pc = pc;
    if_valid = 1'b1;
    ex_branch = 1'b0;
    id_jump = 1'b0;
    pipe_stall = 1'b0;
  endtask

  task automatic br(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic pt);
    ex_branch = 1'b1;
    ex_pc = pc;
    ex_taken = tk;
    ex_target = tgt;
    ex_predtaken = pt;
  endtask

  task automatic adv();
    @(posedge CLK);
    #1;
  endtask

  task automatic sel(input string tag, input pcselect_t exp, input logic fi, input logic fe);
    @(negedge CLK);
    chk({tag, ".sel"}, 32'(pcselect), 32'(exp));
    chk({tag, ".fifid"}, 32'(flush_ifid), 32'(fi));
    chk({tag, ".fidex"}, 32'(flush_idex), 32'(fe));
  endtask

  task automatic counts(input string tag, input int bc, input int mc);
    chk({tag, ".bc"}, branch_count, 32'(bc));
    chk({tag, ".mc"}, mispredict_count, 32'(mc));
  endtask

  initial begin
    #12 RST = 1'b0;
    adv();

    // activity before a mid-run reset
    look(32'h80);
    br(32'h80, 1'b1, 32'h800, 1'b0);
    adv();
    look(32'h80);
    @(negedge CLK);
    chk("pre_rst.bc", branch_count, 32'd1);
    chk("pre_rst.pt", 32'(pred_taken), 32'd1);
    #2 RST = 1'b1;
    #1;
    counts("async_rst", 0, 0);
    chk("async_rst.pt", 32'(pred_taken), 32'd0);
    adv();
    RST = 1'b0;
    adv();

    look(32'h40);
    sel("t1", PCNPC, 1'b0, 1'b0);
    chk("t1.pt", 32'(pred_taken), 32'd0);
    counts("t1", 0, 0);
    adv();

    // first taken branch allocates at counter WT
    br(32'h40, 1'b1, 32'h100, 1'b0);
    sel("t2", PCBPC, 1'b1, 1'b1);
    adv();
    look(32'h40);
    sel("t2b", PCPTA, 1'b0, 1'b0);
    chk("t2b.pt", 32'(pred_taken), 32'd1);
    chk("t2b.tgt", pred_target, 32'h100);
    counts("t2b", 1, 1);
    adv();

    // not-taken mispredict; same-cycle lookup still sees old entry
    br(32'h40, 1'b0, 32'h100, 1'b1);
    sel("t3", PRBPC, 1'b1, 1'b1);
    chk("t3.nobypass", 32'(pred_taken), 32'd1);
    adv();
    look(32'h40);
    sel("t3b", PCNPC, 1'b0, 1'b0);
    chk("t3b.pt", 32'(pred_taken), 32'd0);
    counts("t3b", 2, 2);
    adv();

    // saturation at the ceiling: 01 -> 10 -> 11 -> 11
    br(32'h40, 1'b1, 32'h100, 1'b0);
    sel("t4a", PCBPC, 1'b1, 1'b1);
    adv();
    br(32'h40, 1'b1, 32'h100, 1'b1);
    sel("t4b", PCPTA, 1'b0, 1'b0);
    adv();
    br(32'h40, 1'b1, 32'h100, 1'b1);
    adv();
    look(32'h40);
    @(negedge CLK);
    counts("t4sat", 5, 3);
    adv();
    br(32'h40, 1'b0, 32'h100, 1'b1);
    sel("t4c", PRBPC, 1'b1, 1'b1);
    adv();
    look(32'h40);
    sel("t4d", PCPTA, 1'b0, 1'b0);
    counts("t4d", 6, 4);
    adv();
    br(32'h40, 1'b0, 32'h100, 1'b1);
    adv();
    look(32'h40);
    sel("t4e", PCNPC, 1'b0, 1'b0);
    adv();

    // floor: 01 -> 00 -> 00, then two taken -> 10
    br(32'h40, 1'b0, 32'h100, 1'b0);
    adv();
    br(32'h40, 1'b0, 32'h100, 1'b0);
    sel("t4f", PCNPC, 1'b0, 1'b0);
    adv();
    br(32'h40, 1'b1, 32'h100, 1'b0);
    adv();
    br(32'h40, 1'b1, 32'h100, 1'b0);
    adv();
    look(32'h40);
    sel("t4g", PCPTA, 1'b0, 1'b0);
    counts("t4g", 11, 7);
    adv();

    // alias at index 0 replaces the entry
    br(32'h50, 1'b1, 32'h200, 1'b0);
    adv();
    look(32'h40);
    sel("t5a", PCNPC, 1'b0, 1'b0);
    chk("t5a.tgt", pred_target, 32'h0);
    adv();
    look(32'h50);
    sel("t5b", PCPTA, 1'b0, 1'b0);
    chk("t5b.tgt", pred_target, 32'h200);
    adv();
    look(32'h50);
    if_valid = 1'b0;
    br(32'h44, 1'b0, 32'h400, 1'b0);
    sel("t5c", PCNPC, 1'b0, 1'b0);
    chk("t5c.pt", 32'(pred_taken), 32'd0);
    adv();
    look(32'h44);
    sel("t5d", PCNPC, 1'b0, 1'b0);
    counts("t5d", 13, 8);
    adv();

    // jump priority
    look(32'h50);
    id_jump = 1'b1;
    sel("t6j", PCJPC, 1'b1, 1'b0);
    adv();
    look(32'h50);
    id_jump = 1'b1;
    br(32'h48, 1'b1, 32'h300, 1'b0);
    sel("t6a", PCBPC, 1'b1, 1'b1);
    adv();
    look(32'h50);
    id_jump = 1'b1;
    br(32'h48, 1'b1, 32'h300, 1'b0);
    pipe_stall = 1'b1;
    sel("t6b", PCBPC, 1'b1, 1'b1);
    adv();
    look(32'h4C);
    br(32'h4C, 1'b1, 32'h500, 1'b0);
    pipe_stall = 1'b1;
    adv();
    look(32'h4C);
    sel("t6c", PCNPC, 1'b0, 1'b0);
    counts("t6c", 14, 9);
    look(32'h48);
    #1;
    chk("t6d.tgt", pred_target, 32'h300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/branch_predict_control.md
Name: branch_predict_control

Overview:
- Next-PC sequencing controller for the 5-stage MIPS pipeline.
- Holds a small direct-mapped branch target buffer (BTB) with 2-bit saturating counters, and predicts in IF.
- Resolves predictions against EX branch outcomes and drives the pcselect_t next-PC mux select plus IF/ID and ID/EX flushes.
- Sits beside the hazard control unit; the datapath supplies PC+4, branch, jump and recovery addresses.

Parameters:
- ENTRIES, 4, number of BTB entries (power of 2, ≥2); index = pc[IDXW+1:2], IDXW = log2(ENTRIES).
- CNTW, 32, width of statistics counters.

Ports:
- CLK  in  1  system clock
- RST  in  1  reset, asynchronous, active-high
- if_pc  in  32  PC being fetched
- if_valid  in  1  fetch slot valid
- id_jump  in  1  J/JAL/JR decoded in ID
- ex_branch  in  1  conditional branch resolved in EX
- ex_pc  in  32  PC of the EX branch
- ex_taken  in  1  actual branch outcome
- ex_target  in  32  computed branch target
- ex_predtaken  in  1  prediction carried down the pipe with the branch
- pipe_stall  in  1  EX not advancing this cycle
- pcselect  out  3 (pcselect_t)  next-PC mux select
- pred_taken  out  1  IF prediction, piped with the instruction
- pred_target  out  32  BTB target for PCPTA
- flush_ifid  out  1  squash IF/ID
- flush_idex  out  1  squash ID/EX
- branch_count  out  CNTW  resolved branches
- mispredict_count  out  CNTW  mispredicted branches

Behaviour:
- Reset (async, RST=1):
  - all BTB valid bits 0, counters 2'b01, tags/targets 0.
  - branch_count and mispredict_count = 0.
  - Combinational outputs settle to pcselect=PCNPC, pred_taken=0, flushes 0.
- IF lookup (combinational, zero latency):
  - hit = valid[idx] & tag[idx]==if_pc[31:IDXW+2].
  - pred_taken = if_valid & hit & counter[idx][1].
  - pred_target = target[idx] (0 when not hit).
- Mispredict:
  - mis_t = ex_branch & ex_taken & !ex_predtaken.
  - mis_n = ex_branch & !ex_taken & ex_predtaken.
- pcselect priority, highest first:
  1. mis_t -> PCBPC; flush_ifid=flush_idex=1.
  2. mis_n -> PRBPC (datapath supplies ex_pc+4); flush_ifid=flush_idex=1.
  3. id_jump -> PCJPC; flush_ifid=1.
  4. pred_taken -> PCPTA.
  5. else PCNPC.
- PCERROR5..7 are never driven.
- A tag hit implies a correct target (direct branches only); no target-mismatch recovery.
- Update at posedge, only when ex_branch & !pipe_stall:
  - Tag hit at ex index: counter saturating +1 if taken, -1 if not (00 floor, 11 ceiling).
  - Miss and taken: allocate by overwriting the entry; tag and target from EX, valid=1, counter=2'b10.
  - Miss and not taken: no change.
  - branch_count += 1.
  - mispredict_count += 1 if mis_t|mis_n.
  - Both counters wrap modulo 2^CNTW.
- pipe_stall=1: no table or counter update; pcselect and flushes still driven. The datapath gates PC write.
- Same-index lookup and update in one cycle: lookup sees the pre-update entry (no bypass).
- Reset mid-operation clears state immediately, independent of CLK.

Decomposition:
- Shared package hazard_control_unit_types_pkg gains:
  - btb_entry_t struct {valid, tag, target, cnt}.
  - counter constants SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - pcselect_t stays as is.
- One sub-module: branch_target_buffer, holding storage plus a lookup port and an update port.
- Priority/flush logic and statistics stay in branch_predict_control.

Test Plan (ENTRIES=4):
1. Assert RST mid-run, then deassert; lookup if_pc=0x40 -> pcselect=PCNPC, pred_taken=0, counts 0.
2. EX branch ex_pc=0x40, taken, ex_target=0x100, ex_predtaken=0 -> PCBPC, both flushes 1; next cycle lookup 0x40 -> pred_taken=1, pred_target=0x100, PCPTA; mispredict_count=1.
3. Then 0x40 not taken with ex_predtaken=1 -> PRBPC, both flushes 1; counter 01; lookup 0x40 -> pred_taken=0, PCNPC.
4. Saturation: three taken updates at 0x40 -> counter 11; one not-taken -> 10, lookup still PCPTA; mispredict_count unchanged for the correctly predicted ones.
5. Alias: taken branch at 0x50 (same index 0) -> entry replaced; lookup 0x40 -> miss, PCNPC; lookup 0x50 -> PCPTA.
6. Simultaneous and stall cases:
   - mis_t with id_jump=1 -> PCBPC, flush_ifid=flush_idex=1 (jump ignored).
   - Repeat the same branch with pipe_stall=1 -> branch_count and BTB unchanged, pcselect still PCBPC.
